// File: rtl/proc_pkg.sv
// Shared processor-datapath types for the elastic pipeline stages.
package proc_pkg;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'b00,
    SB_ONE   = 2'b01,
    SB_FULL  = 2'b10
  } sb_state_t;

  localparam int SB_DEPTH = 2;

endpackage

// File: rtl/sb_data_reg.sv
// Enabled data register with asynchronous active-low clear; holds one word of a skid stage.
module sb_data_reg #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_skid_buffer.sv
// Two-entry elastic stage: main register feeds downstream, skid register absorbs one
// word during a stall so in_ready depends only on the state register.
module pipeline_skid_buffer
  import proc_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  sb_state_t        state_reg;
  sb_state_t        state_next;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= SB_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Handshake outputs decode only the state register, never the inputs.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    count     = 2'd0;
    case (state_reg)
      SB_EMPTY: begin
        in_ready = 1'b1;
      end
      SB_ONE: begin
        out_valid = 1'b1;
        in_ready  = 1'b1;
        count     = 2'd1;
      end
      SB_FULL: begin
        out_valid = 1'b1;
        count     = 2'(SB_DEPTH);
      end
      default: ;
    endcase
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    main_en    = 1'b0;
    skid_en    = 1'b0;
    if (flush) begin
      state_next = SB_EMPTY;
    end else begin
      case (state_reg)
        SB_EMPTY: begin
          if (in_fire) begin
            main_en    = 1'b1;
            state_next = SB_ONE;
          end
        end
        SB_ONE: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            skid_en    = 1'b1;
            state_next = SB_FULL;
          end else if (out_fire) begin
            state_next = SB_EMPTY;
          end
        end
        SB_FULL: begin
          if (out_fire) begin
            main_en    = 1'b1;
            state_next = SB_ONE;
          end
        end
        default: state_next = SB_EMPTY;
      endcase
    end
  end

  // Only a drain from FULL promotes the skid word; every other main load takes in_data.
  assign main_d = (state_reg == SB_FULL) ? skid_q : in_data;

  sb_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  sb_data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

  assign out_data = main_q;

endmodule

// File: tb/tb_pipeline_skid_buffer.sv
// Bench for pipeline_skid_buffer: directed scenarios plus random traffic against a queue model.
module tb_pipeline_skid_buffer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [1:0]  count;

  int n_checks;
  int n_fails;

  logic [23:0] model_q[$];
  logic [23:0] log_q[$];

  pipeline_skid_buffer #(.WIDTH(24)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of capacity 2, head presented on out_data.
  task automatic check_outputs(input string tag);
    check_val({tag, ".count"}, 32'(count), 32'(model_q.size()));
    check_val({tag, ".out_valid"}, 32'(out_valid), 32'(model_q.size() > 0));
    check_val({tag, ".in_ready"}, 32'(in_ready), 32'(model_q.size() < 2));
    if (model_q.size() > 0) check_val({tag, ".out_data"}, 32'(out_data), 32'(model_q[0]));
  endtask

  task automatic cycle(input string tag, input logic f, input logic iv,
                       input logic [23:0] d, input logic ordy);
    logic in_acc;
    logic out_acc;
    @(negedge clk);
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    in_acc  = iv && (model_q.size() < 2);
    out_acc = ordy && (model_q.size() > 0);
    if (out_valid && ordy) log_q.push_back(out_data);
    @(posedge clk);
    if (f) begin
      model_q.delete();
    end else begin
      if (out_acc) void'(model_q.pop_front());
      if (in_acc) model_q.push_back(d);
    end
    #1;
    $display("cyc %s flush=%0b iv=%0b d=%06h ordy=%0b -> count=%0d ov=%0b ir=%0b od=%06h",
             tag, f, iv, d, ordy, count, out_valid, in_ready, out_data);
    check_outputs(tag);
  endtask

  task automatic expect_log(input string tag, input logic [23:0] w0, input logic [23:0] w1,
                            input logic [23:0] w2, input int n);
    logic [23:0] exp_w[3];
    exp_w[0] = w0;
    exp_w[1] = w1;
    exp_w[2] = w2;
    check_val({tag, ".log_len"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n && i < log_q.size(); i++)
      check_val($sformatf("%s.log[%0d]", tag, i), 32'(log_q[i]), 32'(exp_w[i]));
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_outputs("reset");
    check_val("reset.out_data", 32'(out_data), 32'h000000);
    cycle("idle", 1'b0, 1'b0, 24'h0, 1'b1);

    // Streaming at full rate
    log_q.delete();
    for (int i = 1; i <= 5; i++) cycle("stream", 1'b0, 1'b1, 24'(i), 1'b1);
    cycle("stream_drain", 1'b0, 1'b0, 24'h0, 1'b1);
    check_val("stream.log_len", 32'(log_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < log_q.size(); i++)
      check_val($sformatf("stream.log[%0d]", i), 32'(log_q[i]), 32'(i + 1));

    // Stall into skid, then backpressured word that must wait
    log_q.delete();
    cycle("stall_w0", 1'b0, 1'b1, 24'hABCDEF, 1'b0);
    cycle("stall_w1", 1'b0, 1'b1, 24'h123456, 1'b0);
    repeat (2) cycle("stall_hold", 1'b0, 1'b0, 24'h0, 1'b0);
    repeat (2) cycle("bp_hold", 1'b0, 1'b1, 24'hDEAD00, 1'b0);
    check_val("bp.out_data_stable", 32'(out_data), 32'hABCDEF);
    repeat (2) cycle("bp_release", 1'b0, 1'b1, 24'hDEAD00, 1'b1);
    repeat (3) cycle("bp_drain", 1'b0, 1'b0, 24'h0, 1'b1);
    check_val("bp.count_empty", 32'(count), 32'd0);
    expect_log("bp", 24'hABCDEF, 24'h123456, 24'hDEAD00, 3);

    // Flush from FULL while offering a word
    log_q.delete();
    cycle("fl_w0", 1'b0, 1'b1, 24'h111111, 1'b0);
    cycle("fl_w1", 1'b0, 1'b1, 24'h222222, 1'b0);
    cycle("flush", 1'b1, 1'b1, 24'h777777, 1'b0);
    check_val("flush.count", 32'(count), 32'd0);
    check_val("flush.out_valid", 32'(out_valid), 32'd0);
    repeat (3) cycle("fl_after", 1'b0, 1'b0, 24'h0, 1'b1);
    check_val("flush.log_len", 32'(log_q.size()), 32'd0);

    // Randomized traffic
    log_q.delete();
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 15) == 0), 1'($urandom), 24'($urandom),
            ($urandom_range(0, 3) != 0));
      foreach (log_q[k]) begin
        if (log_q[k] === 24'h777777) check_val("rand.no_flushed_word", 32'(log_q[k]), 32'h0);
      end
    end

    // Asynchronous reset while FULL
    cycle("ar_w0", 1'b0, 1'b1, 24'h0A0A0A, 1'b0);
    cycle("ar_w1", 1'b0, 1'b1, 24'h0B0B0B, 1'b0);
    check_val("ar.pre_count", 32'(count), 32'd2);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_q.delete();
    check_outputs("async_reset");
    check_val("async_reset.out_data", 32'(out_data), 32'h000000);
    @(negedge clk);
    reset = 1'b1;
    cycle("post_reset", 1'b0, 1'b1, 24'h5A5A5A, 1'b1);
    cycle("post_reset2", 1'b0, 1'b0, 24'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
